// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - received-byte valid/ready handshake bundle
interface uart_byte_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver with a one-byte valid/ready holding register
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_byte_rx_if.master bus,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            bus.data  <= 8'h00;
            bus.valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (bus.valid && bus.ready)
                bus.valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxs;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a directly following start bit be caught.
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!bus.valid || bus.ready) begin
                                bus.data  <= shreg;
                                bus.valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx (fast-baud and 868-clock instances)
module tb_uart_byte_rx;
    localparam int FC      = 16;
    localparam int SC      = 868;
    localparam int LAT_EXP = 4 + (SC / 2) + 9 * SC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_f = 1'b1, rx_s = 1'b1;
    logic fe_f, ov_f, busy_f, fe_s, ov_s, busy_s;

    uart_byte_rx_if bf ();
    uart_byte_rx_if bs ();

    uart_byte_rx #(.CLKS_PER_BIT(FC)) dut_f (
        .clk(clk), .rst(rst), .rx(rx_f), .bus(bf.master),
        .frame_err(fe_f), .overrun(ov_f), .busy(busy_f));

    uart_byte_rx #(.CLKS_PER_BIT(SC)) dut_s (
        .clk(clk), .rst(rst), .rx(rx_s), .bus(bs.master),
        .frame_err(fe_s), .overrun(ov_s), .busy(busy_s));

    int n_pass = 0, n_total = 0;
    int fe_cnt_f = 0, ov_cnt_f = 0, fe_cnt_s = 0, ov_cnt_s = 0;
    int cyc = 0, t_start_s = 0;
    bit busy_seen_s = 0;
    int exp_f[$];
    int exp_s[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: samples 1 time unit after the falling edge, pops the scoreboard on each handshake.
    always begin
        @(negedge clk);
        #1;
        if (fe_f) fe_cnt_f++;
        if (ov_f) ov_cnt_f++;
        if (fe_s) fe_cnt_s++;
        if (ov_s) ov_cnt_s++;
        if (busy_s) busy_seen_s = 1;
        if (bf.valid && bf.ready) begin
            if (exp_f.size() == 0) chk("f_spurious_valid", int'(bf.data), -1);
            else chk("f_data", int'(bf.data), exp_f.pop_front());
        end
        if (bs.valid && bs.ready) begin
            if (exp_s.size() == 0) chk("s_spurious_valid", int'(bs.data), -1);
            else begin
                int lat;
                chk("s_data", int'(bs.data), exp_s.pop_front());
                lat = cyc - t_start_s;
                n_total++;
                if (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) n_pass++;
                else $display("FAIL s_latency: got %0d cycles, expected %0d +-1", lat, LAT_EXP);
            end
        end
    end

    task automatic drive(input bit slow, input logic v, input int nbits);
        if (slow) rx_s = v; else rx_f = v;
        repeat (nbits * (slow ? SC : FC)) @(negedge clk);
    endtask

    task automatic send(input bit slow, input logic [7:0] b, input logic stop_bit);
        drive(slow, 1'b0, 1);
        for (int i = 0; i < 8; i++) drive(slow, b[i], 1);
        drive(slow, stop_bit, 1);
        if (slow) rx_s = 1'b1; else rx_f = 1'b1;
    endtask

    task automatic drain(input bit slow, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((slow ? exp_s.size() : exp_f.size()) == 0) break;
            @(negedge clk);
        end
        #2;
        if (slow) chk("s_drain", exp_s.size(), 0);
        else      chk("f_drain", exp_f.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0, fe0;
        bf.ready = 1'b1;
        bs.ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valid_f", bf.valid, 0);
        chk("rst_data_f", int'(bf.data), 0);
        chk("rst_busy_f", busy_f, 0);
        chk("rst_fe_ov_f", {fe_f, ov_f}, 0);
        chk("rst_valid_s", bs.valid, 0);
        chk("rst_busy_s", busy_s, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of the data bits, released with the line idle.
        drive(0, 1'b0, 3);
        #2;
        chk("mid_busy", busy_f, 1);
        rx_f = 1'b1;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * FC) @(negedge clk);
        #2;
        chk("post_rst_valid", bf.valid, 0);
        chk("post_rst_busy", busy_f, 0);
        chk("post_rst_fe", fe_cnt_f, 0);
        @(negedge clk);
        exp_f.push_back(8'h3C);
        send(0, 8'h3C, 1'b1);
        drive(0, 1'b1, 1);
        drain(0, 4 * FC);

        // Stop bit 0 then line held low: one frame_err, no byte.
        fe0 = fe_cnt_f;
        drive(0, 1'b0, 1);
        for (int i = 0; i < 8; i++) drive(0, (8'h55 >> i) & 1'b1, 1);
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 2);
        chk("break_fe_pulses", fe_cnt_f - fe0, 1);
        chk("break_busy", busy_f, 0);
        exp_f.push_back(8'h01);
        send(0, 8'h01, 1'b1);
        drive(0, 1'b1, 1);
        drain(0, 4 * FC);

        // Overrun: consumer stalled across two frames.
        bf.ready = 1'b0;
        ov0 = ov_cnt_f;
        exp_f.push_back(8'h11);
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        drive(0, 1'b1, 1);
        #2;
        chk("ovr_pulses", ov_cnt_f - ov0, 1);
        chk("ovr_valid_held", bf.valid, 1);
        chk("ovr_data_held", int'(bf.data), 8'h11);
        @(negedge clk);
        bf.ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("ovr_valid_drop", bf.valid, 0);
        chk("ovr_data_kept", int'(bf.data), 8'h11);
        drain(0, 2);

        // Back-to-back frames, no idle gap.
        fe0 = fe_cnt_f;
        ov0 = ov_cnt_f;
        exp_f.push_back(8'h00);
        exp_f.push_back(8'hFF);
        exp_f.push_back(8'h80);
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        send(0, 8'h80, 1'b1);
        drive(0, 1'b1, 1);
        drain(0, 4 * FC);
        chk("b2b_fe", fe_cnt_f - fe0, 0);
        chk("b2b_ov", ov_cnt_f - ov0, 0);

        // Slow instance: 100-cycle glitch is rejected, then 0xA5 with latency check.
        @(negedge clk);
        busy_seen_s = 0;
        rx_s = 1'b0;
        repeat (100) @(negedge clk);
        rx_s = 1'b1;
        repeat (600) @(negedge clk);
        #2;
        chk("glitch_busy_seen", busy_seen_s, 1);
        chk("glitch_busy_idle", busy_s, 0);
        chk("glitch_fe", fe_cnt_s, 0);
        @(negedge clk);
        exp_s.push_back(8'hA5);
        t_start_s = cyc;
        send(1, 8'hA5, 1'b1);
        drain(1, 4 * SC);
        chk("s_fe_ov", fe_cnt_s + ov_cnt_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
